dram_refresh_scheduler: RTL and testbench

- Generates CAS-before-RAS refresh requests for the FastRAM DRAM controller. Sits directly upstream of the RAS/CAS sequencer and feeds it `ref_req`.
- Counts refresh intervals and tracks a backlog of owed refreshes. Requests are issued only into idle bus time, unless the backlog becomes urgent.
- The downstream sequencer performs the CBR cycle and pulses `ref_done` back.

---
 rtl/dram_refresh_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_dram_refresh_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// dram_refresh_scheduler
//
// Generates CAS-before-RAS refresh requests for the FastRAM DRAM controller.
// An interval counter produces one refresh "tick" every REFRESH_INTERVAL
// clocks. Ticks accumulate in a saturating backlog (pending). Refreshes are
// requested from the downstream RAS/CAS sequencer only in idle bus time,
// unless the backlog reaches URGENT_LEVEL, in which case the request is
// forced and ref_urgent tells the sequencer to hold off new RAM cycles.
//
// Ports:
//   CLK        in   system clock, all state changes on the rising edge
//   RESETn     in   asynchronous active-low reset
//   AS         in   bus cycle active (1 = CPU cycle in progress), sync to CLK
//   refresh_en in   scheduler enable
//   ref_done   in   one-CLK pulse: one CBR refresh completed by the sequencer
//   ref_req    out  registered refresh request
//   ref_urgent out  registered (pending >= URGENT_LEVEL)
//   pending    out  current backlog of owed refreshes
//   overflow   out  sticky: a tick was lost while the backlog was saturated
//
// Build option:
//   REFRESH_BURST_EN  when defined, a ref_done that leaves work outstanding
//                     while the bus is idle keeps ref_req high so the backlog
//                     drains back-to-back. When undefined, every refresh needs
//                     a fresh GUARD_CLKS idle qualification.
// -----------------------------------------------------------------------------
module dram_refresh_scheduler #(
  parameter int REFRESH_INTERVAL = 110,
  parameter int MAX_PENDING      = 8,
  parameter int URGENT_LEVEL     = 4,
  parameter int GUARD_CLKS       = 2
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       AS,
  input  logic       refresh_en,
  input  logic       ref_done,
  output logic       ref_req,
  output logic       ref_urgent,
  output logic [3:0] pending,
  output logic       overflow
);

  localparam int CNT_W  = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int IDLE_W = (GUARD_CLKS > 0) ? $clog2(GUARD_CLKS + 1) : 1;

  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]        MAX_P  = 4'(MAX_PENDING);
  localparam logic [3:0]        URG_P  = 4'(URGENT_LEVEL);
  localparam logic [IDLE_W-1:0] GUARD  = IDLE_W'(GUARD_CLKS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_REQ  = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  int_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic       tick;
  logic [3:0] pending_nxt;
  logic       ovf_set;
  logic       idle;
  logic       burst_hold;
  logic       requal;

  // ---------------------------------------------------------------------------
  // Interval tick and backlog arithmetic
  // ---------------------------------------------------------------------------
  assign tick = refresh_en && (int_cnt == '0);
  assign idle = (idle_cnt == GUARD);

  // Next backlog value. A tick and a ref_done in the same clock cancel, so the
  // backlog is unchanged and a saturated backlog does not report a lost tick.
  always_comb begin
    pending_nxt = pending;
    ovf_set     = 1'b0;
    if (!refresh_en) begin
      pending_nxt = '0;
    end else if (tick && !ref_done) begin
      if (pending == MAX_P) begin
        ovf_set = 1'b1;
      end else begin
        pending_nxt = pending + 4'd1;
      end
    end else if (ref_done && !tick) begin
      if (pending != '0) begin
        pending_nxt = pending - 4'd1;
      end
    end
  end

`ifdef REFRESH_BURST_EN
  // Keep requesting straight after a completed refresh while the bus is idle.
  assign burst_hold = ~AS;
`else
  assign burst_hold = 1'b0;
`endif

  // A refresh completed with more work owed but no burst continuation: the
  // next request has to requalify the bus as idle from scratch.
  assign requal = refresh_en && (state == S_REQ) && ref_done &&
                  (pending_nxt != '0) && !burst_hold;

  // ---------------------------------------------------------------------------
  // Counter, backlog, idle qualification and urgency registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      int_cnt <= RELOAD;
    end else if (!refresh_en || (int_cnt == '0)) begin
      int_cnt <= RELOAD;
    end else begin
      int_cnt <= int_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      // overflow is sticky and survives refresh_en = 0
      overflow <= overflow | ovf_set;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      idle_cnt <= '0;
    end else if (AS || requal) begin
      idle_cnt <= '0;
    end else if (idle_cnt != GUARD) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Urgency follows the registered backlog one clock later; it is dropped
  // immediately when the scheduler is disabled since the backlog is cleared.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ref_urgent <= 1'b0;
    end else if (!refresh_en) begin
      ref_urgent <= 1'b0;
    end else begin
      ref_urgent <= (pending >= URG_P);
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM. Decisions look at the next backlog value so that a tick moves
  // IDLE->ARM in the same clock the backlog increments, giving the two-clock
  // tick-to-request latency on an idle bus.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= S_IDLE;
      ref_req <= 1'b0;
    end else if (!refresh_en) begin
      state   <= S_IDLE;
      ref_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pending_nxt != '0) begin
            state   <= S_ARM;
            ref_req <= 1'b0;
          end else begin
            state   <= S_IDLE;
            ref_req <= 1'b0;
          end
        end

        S_ARM: begin
          if (pending_nxt == '0) begin
            state   <= S_IDLE;
            ref_req <= 1'b0;
          end else if (idle || ref_urgent) begin
            state   <= S_REQ;
            ref_req <= 1'b1;
          end else begin
            state   <= S_ARM;
            ref_req <= 1'b0;
          end
        end

        S_REQ: begin
          if (ref_done) begin
            if (pending_nxt == '0) begin
              state   <= S_IDLE;
              ref_req <= 1'b0;
            end else if (burst_hold) begin
              state   <= S_REQ;
              ref_req <= 1'b1;
            end else begin
              state   <= S_ARM;
              ref_req <= 1'b0;
            end
          end else if (AS && !ref_urgent) begin
            // CPU took the bus before the refresh started: withdraw.
            state   <= S_ARM;
            ref_req <= 1'b0;
          end else begin
            state   <= S_REQ;
            ref_req <= 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          ref_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_refresh_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dram_refresh_scheduler
//
// Directed and randomized stimulus for dram_refresh_scheduler. A behavioural
// model tracks enabled cycles, backlog, idle run length and request phase from
// the scheduling rules; every clock the DUT outputs are compared against it,
// and directed steps add fixed-value checks for the key timing points.
// -----------------------------------------------------------------------------
module tb_dram_refresh_scheduler;

  localparam int INTERVAL = 110;
  localparam int MAXP     = 8;
  localparam int URG      = 4;
  localparam int GUARD    = 2;

`ifdef REFRESH_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_REQ  = 2;

  logic       CLK;
  logic       RESETn;
  logic       AS;
  logic       refresh_en;
  logic       ref_done;
  logic       ref_req;
  logic       ref_urgent;
  logic [3:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // model state
  int m_en_cycles;
  int m_pend;
  bit m_ovf;
  bit m_urg;
  int m_mode;
  int m_idle_run;
  int m_ticks = 0;

  dram_refresh_scheduler #(
    .REFRESH_INTERVAL(INTERVAL),
    .MAX_PENDING     (MAXP),
    .URGENT_LEVEL    (URG),
    .GUARD_CLKS      (GUARD)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .AS        (AS),
    .refresh_en(refresh_en),
    .ref_done  (ref_done),
    .ref_req   (ref_req),
    .ref_urgent(ref_urgent),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_en_cycles = 0;
    m_pend      = 0;
    m_ovf       = 1'b0;
    m_urg       = 1'b0;
    m_mode      = M_IDLE;
    m_idle_run  = 0;
  endtask

  // One rising edge of the reference behaviour, using the inputs as sampled.
  task automatic model_edge();
    int newp;
    bit tick;
    bit requal;
    bit idle0;
    bit urg0;
    if (!RESETn) begin
      model_reset();
      return;
    end
    idle0  = (m_idle_run >= GUARD);
    urg0   = m_urg;
    requal = 1'b0;
    if (!refresh_en) begin
      m_en_cycles = 0;
      m_pend      = 0;
      m_mode      = M_IDLE;
      m_urg       = 1'b0;
    end else begin
      m_en_cycles++;
      tick = (m_en_cycles % INTERVAL == 0);
      if (tick) m_ticks++;
      newp = m_pend;
      if (tick && !ref_done) begin
        if (m_pend == MAXP) m_ovf = 1'b1;
        else newp = m_pend + 1;
      end else if (ref_done && !tick && m_pend > 0) begin
        newp = m_pend - 1;
      end
      m_urg = (m_pend >= URG);
      case (m_mode)
        M_IDLE: if (newp > 0) m_mode = M_ARM;
        M_ARM: begin
          if (newp == 0) m_mode = M_IDLE;
          else if (idle0 || urg0) m_mode = M_REQ;
        end
        default: begin
          if (ref_done) begin
            if (newp == 0) m_mode = M_IDLE;
            else if (BURST && !AS) m_mode = M_REQ;
            else begin
              m_mode = M_ARM;
              requal = 1'b1;
            end
          end else if (AS && !urg0) begin
            m_mode = M_ARM;
          end
        end
      endcase
      m_pend = newp;
    end
    if (AS || requal) m_idle_run = 0;
    else if (m_idle_run < GUARD) m_idle_run++;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("ref_req", ref_req, (m_mode == M_REQ));
    chk("ref_urgent", ref_urgent, m_urg);
    chk("pending", pending, m_pend);
    chk("overflow", overflow, m_ovf);
  endtask

  function automatic bit tick_next();
    return refresh_en && ((m_en_cycles + 1) % INTERVAL == 0);
  endfunction

  task automatic wait_pend(input int target, input int budget);
    int n;
    n = 0;
    while (m_pend != target && n < budget) begin
      step();
      n++;
    end
    chk("wait_pend", pending, target);
  endtask

  task automatic drain();
    int n;
    n = 0;
    AS = 1'b0;
    while ((m_pend != 0 || m_mode != M_IDLE) && n < 600) begin
      ref_done = (m_mode == M_REQ);
      step();
      ref_done = 1'b0;
      n++;
    end
    chk("drain_pend", pending, 0);
  endtask

  initial begin
    int base;
    int n;
    int p;

    RESETn     = 1'b0;
    AS         = 1'b0;
    refresh_en = 1'b0;
    ref_done   = 1'b0;
    model_reset();
    repeat (2) step();
    chk("rst_req", ref_req, 0);
    chk("rst_urg", ref_urgent, 0);
    chk("rst_pend", pending, 0);
    chk("rst_ovf", overflow, 0);

    // Basic tick and request on a permanently idle bus
    RESETn     = 1'b1;
    refresh_en = 1'b1;
    repeat (109) step();
    chk("t1_pend_pre", pending, 0);
    step();
    chk("t1_pend_tick", pending, 1);
    chk("t1_req_early", ref_req, 0);
    step();
    chk("t1_req", ref_req, 1);
    repeat (3) step();
    ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    chk("t1_req_off", ref_req, 0);
    chk("t1_pend_done", pending, 0);

    // Guard qualification and withdrawal
    AS = 1'b1;
    wait_pend(1, 200);
    repeat (3) step();
    chk("t2_req_busy", ref_req, 0);
    AS = 1'b0;
    step();
    chk("t2_req_g1", ref_req, 0);
    step();
    chk("t2_req_g2", ref_req, 0);
    step();
    chk("t2_req_guard", ref_req, 1);
    AS = 1'b1;
    step();
    chk("t2_req_withdraw", ref_req, 0);
    chk("t2_pend", pending, 1);
    AS = 1'b0;
    repeat (3) step();
    chk("t2_req_again", ref_req, 1);
    ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    chk("t2_pend_done", pending, 0);

    // Urgent override with the bus busy
    AS = 1'b1;
    wait_pend(4, 600);
    chk("t3_urg_pre", ref_urgent, 0);
    step();
    chk("t3_urg", ref_urgent, 1);
    chk("t3_req_pre", ref_req, 0);
    step();
    chk("t3_req_forced", ref_req, 1);
    repeat (5) step();
    chk("t3_req_hold", ref_req, 1);
    drain();

    // Simultaneous tick and ref_done at pending = 3
    AS = 1'b1;
    wait_pend(3, 400);
    AS = 1'b0;
    repeat (3) step();
    chk("t5_req", ref_req, 1);
    n = 0;
    while (!tick_next() && n < 200) begin
      step();
      n++;
    end
    ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    chk("t5_pend_same", pending, 3);
    chk("t5_ovf", overflow, 0);
    drain();
    if (tick_next()) step();
    ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    chk("t5_no_wrap", pending, 0);

    // Saturation and sticky overflow
    AS   = 1'b1;
    base = m_ticks;
    n    = 0;
    while (m_ticks < base + 8 && n < 1000) begin
      step();
      n++;
    end
    chk("t4_pend_8", pending, 8);
    chk("t4_ovf_pre", overflow, 0);
    n = 0;
    while (m_ticks < base + 9 && n < 200) begin
      step();
      n++;
    end
    chk("t4_pend_sat", pending, 8);
    chk("t4_ovf", overflow, 1);
    drain();
    chk("t4_ovf_kept", overflow, 1);

    // Disable clears the backlog but keeps overflow
    AS = 1'b1;
    wait_pend(2, 300);
    refresh_en = 1'b0;
    step();
    chk("en_pend", pending, 0);
    chk("en_req", ref_req, 0);
    chk("en_urg", ref_urgent, 0);
    chk("en_ovf", overflow, 1);
    repeat (3) step();
    refresh_en = 1'b1;

    // Back-to-back refreshes (burst build) or single refresh per qualification
    AS = 1'b1;
    wait_pend(3, 400);
    AS = 1'b0;
    repeat (3) step();
    chk("b_req", ref_req, 1);
`ifdef REFRESH_BURST_EN
    for (int k = 0; k < 3; k++) begin
      repeat (3) begin
        step();
        chk("burst_hold", ref_req, 1);
      end
      ref_done = 1'b1;
      step();
      ref_done = 1'b0;
      chk("burst_pend", pending, 2 - k);
      chk("burst_req", ref_req, (k < 2));
    end
`else
    repeat (3) step();
    ref_done = 1'b1;
    step();
    ref_done = 1'b0;
    chk("single_req_drop", ref_req, 0);
    chk("single_pend", pending, 2);
    drain();
`endif

    // Randomized traffic
    for (int blk = 0; blk < 12; blk++) begin
      p = $urandom_range(0, 3);
      for (int i = 0; i < 400; i++) begin
        case (p)
          0:       AS = ($urandom_range(0, 9) == 0);
          1:       AS = $urandom_range(0, 1);
          2:       AS = ($urandom_range(0, 9) != 0);
          default: AS = 1'b1;
        endcase
        refresh_en = ($urandom_range(0, 299) != 0);
        ref_done   = (m_mode == M_REQ) && ($urandom_range(0, 2) == 0);
        step();
      end
    end
    refresh_en = 1'b1;
    ref_done   = 1'b0;
    drain();

    // Asynchronous reset in the middle of a forced request
    AS = 1'b1;
    wait_pend(5, 700);
    chk("r_req_before", ref_req, 1);
    #2 RESETn = 1'b0;
    #1;
    chk("r_req", ref_req, 0);
    chk("r_urg", ref_urgent, 0);
    chk("r_pend", pending, 0);
    chk("r_ovf", overflow, 0);
    model_reset();
    repeat (2) step();
    RESETn = 1'b1;
    AS     = 1'b0;
    repeat (5) step();
    chk("r_pend_after", pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
